// File: rtl/sync_fifo.sv
// Synchronous FIFO between the operand counters and the systolic array feed.
// Pointers and occupancy are enable-gated wrap-around counters; storage is not reset.
module sync_fifo_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;
  end
endmodule

module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_BIT:0]     cnt_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  localparam int DEPTH = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT:0] DEPTH_C = (ADDR_BIT+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BIT-1:0]   wptr, rptr;
  logic                  wr_acc, rd_acc;

  assign empty_o = (cnt_o == '0);
  assign full_o  = (cnt_o == DEPTH_C);
  assign wr_acc  = wr_en_i & ~full_o;
  assign rd_acc  = rd_en_i & ~empty_o;

  sync_fifo_cnt #(.W(ADDR_BIT)) u_wptr (
    .clk(clk), .rst_n(rst_n), .en(wr_acc), .up(1'b1), .q(wptr)
  );
  sync_fifo_cnt #(.W(ADDR_BIT)) u_rptr (
    .clk(clk), .rst_n(rst_n), .en(rd_acc), .up(1'b1), .q(rptr)
  );
  // Occupancy only moves when exactly one side is accepted; acceptance gating keeps it in 0..DEPTH.
  sync_fifo_cnt #(.W(ADDR_BIT+1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(wr_acc ^ rd_acc), .up(wr_acc), .q(cnt_o)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      ovf_o      <= 1'b0;
      udf_o      <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      if (rd_acc) rd_data_o <= mem[rptr];
      if (wr_en_i & full_o)  ovf_o <= 1'b1;
      if (rd_en_i & empty_o) udf_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus queues expected read data, a monitor pops on rd_valid_o.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       rd_en_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [2:0] cnt_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  sync_fifo #(.DATA_WIDTH(8), .ADDR_BIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .full_o(full_o), .empty_o(empty_o), .cnt_o(cnt_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; a read expected to be accepted queues its word.
  task automatic op(input logic wr, input logic [7:0] d, input logic rd,
                    input logic rd_ok, input logic [7:0] rd_exp);
    wr_en_i = wr; wr_data_i = d; rd_en_i = rd;
    if (rd_ok) exp_q.push_back(rd_exp);
    @(posedge clk); #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
  endtask

  task automatic status(input string tag, input logic [2:0] c, input logic f,
                        input logic e, input logic o, input logic u);
    chk({tag, " cnt"}, 32'(cnt_o), 32'(c));
    chk({tag, " full"}, 32'(full_o), 32'(f));
    chk({tag, " empty"}, 32'(empty_o), 32'(e));
    chk({tag, " ovf"}, 32'(ovf_o), 32'(o));
    chk({tag, " udf"}, 32'(udf_o), 32'(u));
  endtask

  // Monitor: every presented word must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: got 0x%0h expected no valid", rd_data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data_o), 32'(e));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", 32'(rd_data_o), 32'h0);
    chk("reset rd_valid", 32'(rd_valid_o), 32'h0);
    status("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill
    op(1, 8'h11, 0, 0, 8'h00); chk("fill cnt1", 32'(cnt_o), 1);
    op(1, 8'h22, 0, 0, 8'h00); chk("fill cnt2", 32'(cnt_o), 2);
    op(1, 8'h33, 0, 0, 8'h00); chk("fill cnt3", 32'(cnt_o), 3);
    op(1, 8'h44, 0, 0, 8'h00); status("full", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overflow: 0x55 must be dropped
    op(1, 8'h55, 0, 0, 8'h00); status("ovf", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain
    op(0, 8'h00, 1, 1, 8'h11);
    chk("drain valid", 32'(rd_valid_o), 1);
    op(0, 8'h00, 1, 1, 8'h22);
    op(0, 8'h00, 1, 1, 8'h33);
    op(0, 8'h00, 1, 1, 8'h44);
    chk("drain valid4", 32'(rd_valid_o), 1);
    status("drained", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Underflow
    op(0, 8'h00, 1, 0, 8'h00);
    chk("udf valid", 32'(rd_valid_o), 0);
    chk("udf data hold", 32'(rd_data_o), 32'h44);
    status("udf", 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Empty with both: write wins, no bypass
    op(1, 8'hA5, 1, 0, 8'h00);
    chk("empty both valid", 32'(rd_valid_o), 0);
    chk("empty both cnt", 32'(cnt_o), 1);
    op(0, 8'h00, 1, 1, 8'hA5);
    chk("a5 cnt", 32'(cnt_o), 0);

    // Full with both: read wins, write of 0xC0 rejected
    op(1, 8'hB1, 0, 0, 8'h00);
    op(1, 8'hB2, 0, 0, 8'h00);
    op(1, 8'hB3, 0, 0, 8'h00);
    op(1, 8'hB4, 0, 0, 8'h00);
    op(1, 8'hC0, 1, 1, 8'hB1);
    status("full both", 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    op(0, 8'h00, 1, 1, 8'hB2);
    op(0, 8'h00, 1, 1, 8'hB3);
    op(0, 8'h00, 1, 1, 8'hB4);
    chk("pre-reset valid", 32'(rd_valid_o), 1);

    // Asynchronous reset mid-cycle, after the monitor sampled B4
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async rd_valid", 32'(rd_valid_o), 0);
    chk("async rd_data", 32'(rd_data_o), 0);
    status("async", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Wrap-around stream at occupancy 2
    op(1, 8'h00, 0, 0, 8'h00);
    op(1, 8'h01, 0, 0, 8'h00);
    for (int i = 2; i < 16; i++) begin
      op(1, 8'(i), 1, 1, 8'(i - 2));
      chk("stream cnt", 32'(cnt_o), 2);
    end
    op(0, 8'h00, 1, 1, 8'h0E);
    op(0, 8'h00, 1, 1, 8'h0F);
    status("stream", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with three stale words
    op(1, 8'hD1, 0, 0, 8'h00);
    op(1, 8'hD2, 0, 0, 8'h00);
    op(1, 8'hD3, 0, 0, 8'h00);
    chk("midrst cnt3", 32'(cnt_o), 3);
    rst_n = 1'b0; #1;
    chk("midrst cnt0", 32'(cnt_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(1, 8'h77, 0, 0, 8'h00);
    chk("post-rst cnt", 32'(cnt_o), 1);
    op(0, 8'h00, 1, 1, 8'h77);
    status("post-rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
